// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 8:1 data mux; bursts of up to BURST_MAX beats per grant.
// Optional MUX_ARB_LOCK_EN adds lockIn, which holds a grant past the burst limit.
module rr_mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [7:0]            reqIn,
  input  logic [8*DATA_W-1:0]   dataIn,
  input  logic                  outReady,
`ifdef MUX_ARB_LOCK_EN
  input  logic                  lockIn,
`endif
  output logic [7:0]            grantOut,
  output logic [2:0]            selectLine,
  output logic                  outValid,
  output logic [DATA_W-1:0]     dataOut
);

  typedef enum logic [0:0] {IDLE, GRANT} arbStateT;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_MAX - 1);

  arbStateT          state, stateNext;
  logic [7:0]        grantNext;
  logic [2:0]        selNext;
  logic [3:0]        beatCount, beatNext;
  logic [2:0]        lastSel, lastSelNext;

  logic [2:0]        arbBase;
  logic [2:0]        scanIdx;
  logic [2:0]        winIdx;
  logic              winFound;
  logic              lockActive;
  logic              transfer;
  logic              lastBeat;
  logic              releaseGrant;
  logic [DATA_W-1:0] words [8];

`ifdef MUX_ARB_LOCK_EN
  assign lockActive = lockIn;
`else
  assign lockActive = 1'b0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      words[i] = dataIn[i*DATA_W +: DATA_W];
    end
  end

  assign outValid = (state == GRANT) && reqIn[selectLine];
  assign dataOut  = outValid ? words[selectLine] : '0;
  assign transfer = outValid && outReady;
  assign lastBeat = (beatCount == LAST_BEAT);

  assign releaseGrant = (state == GRANT) &&
                        (!reqIn[selectLine] || (transfer && lastBeat && !lockActive));

  // In GRANT the search pivots on selectLine so a release can re-arbitrate at the same edge
  // with the rotation that lastSel will hold afterwards.
  always_comb begin
    arbBase  = (state == GRANT) ? selectLine : lastSel;
    winFound = 1'b0;
    winIdx   = '0;
    scanIdx  = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      scanIdx = arbBase + 3'(k);
      if (!winFound && reqIn[scanIdx]) begin
        winFound = 1'b1;
        winIdx   = scanIdx;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    selNext     = selectLine;
    grantNext   = grantOut;
    beatNext    = beatCount;
    lastSelNext = lastSel;
    case (state)
      IDLE: begin
        if (winFound) begin
          stateNext = GRANT;
          selNext   = winIdx;
          grantNext = 8'b1 << winIdx;
          beatNext  = '0;
        end
      end
      GRANT: begin
        if (releaseGrant) begin
          lastSelNext = selectLine;
          beatNext    = '0;
          if (winFound) begin
            selNext   = winIdx;
            grantNext = 8'b1 << winIdx;
          end else begin
            stateNext = IDLE;
            grantNext = '0;
          end
        end else if (transfer) begin
          // Under lock the count parks at the last beat so dropping lockIn releases on the next transfer.
          beatNext = (lockActive && lastBeat) ? beatCount : beatCount + 4'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      selectLine <= '0;
      grantOut   <= '0;
      beatCount  <= '0;
      lastSel    <= 3'd7;
    end else begin
      state      <= stateNext;
      selectLine <= selNext;
      grantOut   <= grantNext;
      beatCount  <= beatNext;
      lastSel    <= lastSelNext;
    end
  end

  grantOneHot: assert property (@(posedge clk) disable iff (!rstN) $onehot0(grantOut));

  grantMatchesSel: assert property (@(posedge clk) disable iff (!rstN)
    (grantOut == '0) || (grantOut == (8'b1 << selectLine)));

  grantMatchesState: assert property (@(posedge clk) disable iff (!rstN)
    (state == GRANT) == (grantOut != '0));

  beatInRange: assert property (@(posedge clk) disable iff (!rstN) beatCount <= LAST_BEAT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, bursts, rotation, backpressure, early drop, async reset, lock.
module tb_rr_mux_arbiter;

  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 4;

  logic                clk;
  logic                rstN;
  logic [7:0]          reqIn;
  logic [8*DATA_W-1:0] dataIn;
  logic                outReady;
  logic                lockIn;
  logic [7:0]          grantOut;
  logic [2:0]          selectLine;
  logic                outValid;
  logic [DATA_W-1:0]   dataOut;

  int compared;
  int mismatched;

  rr_mux_arbiter #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .reqIn      (reqIn),
    .dataIn     (dataIn),
    .outReady   (outReady),
`ifdef MUX_ARB_LOCK_EN
    .lockIn     (lockIn),
`endif
    .grantOut   (grantOut),
    .selectLine (selectLine),
    .outValid   (outValid),
    .dataOut    (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] wordOf(input int idx);
    return dataIn[idx*DATA_W +: DATA_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN     = 1'b0;
    reqIn    = '0;
    outReady = 1'b0;
    lockIn   = 1'b0;
    step();
    step();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    for (int c = 0; c < 5; c++) begin
      if (grantOut !== 8'h00) begin $display("FAIL reset_grant cyc%0d got %h want 00", c, grantOut); mismatched++; end
      compared++;
      if (selectLine !== 3'd0) begin $display("FAIL reset_sel cyc%0d got %0d want 0", c, selectLine); mismatched++; end
      compared++;
      if (outValid !== 1'b0) begin $display("FAIL reset_valid cyc%0d got %b want 0", c, outValid); mismatched++; end
      compared++;
      if (dataOut !== 8'h00) begin $display("FAIL reset_data cyc%0d got %h want 00", c, dataOut); mismatched++; end
      compared++;
      step();
    end
  endtask

  task automatic test_single_burst();
    doReset();
    dataIn[3*DATA_W +: DATA_W] = 8'hA5;
    reqIn    = 8'h08;
    outReady = 1'b1;
    #1;
    if (outValid !== 1'b0) begin $display("FAIL single_pregrant_valid got %b want 0", outValid); mismatched++; end
    compared++;
    step();
    // First granted cycle plus 8 more: the burst boundary at beat 4 must show no gap.
    for (int c = 0; c < 9; c++) begin
      if (grantOut !== 8'h08) begin $display("FAIL single_grant cyc%0d got %h want 08", c, grantOut); mismatched++; end
      compared++;
      if (selectLine !== 3'd3) begin $display("FAIL single_sel cyc%0d got %0d want 3", c, selectLine); mismatched++; end
      compared++;
      if (outValid !== 1'b1) begin $display("FAIL single_valid cyc%0d got %b want 1", c, outValid); mismatched++; end
      compared++;
      if (dataOut !== 8'hA5) begin $display("FAIL single_data cyc%0d got %h want a5", c, dataOut); mismatched++; end
      compared++;
      step();
    end
    reqIn = 8'h00;
    step();
    if (grantOut !== 8'h00) begin $display("FAIL single_idle_grant got %h want 00", grantOut); mismatched++; end
    compared++;
  endtask

  task automatic test_rotation();
    logic [2:0] expSel;
    logic [7:0] expGrant;
    doReset();
    reqIn    = 8'hFF;
    outReady = 1'b1;
    step();
    for (int g = 0; g < 9; g++) begin
      expSel   = 3'(g % 8);
      expGrant = 8'h01 << expSel;
      for (int b = 0; b < BURST_MAX; b++) begin
        if (selectLine !== expSel) begin $display("FAIL rot_sel g%0d b%0d got %0d want %0d", g, b, selectLine, expSel); mismatched++; end
        compared++;
        if (grantOut !== expGrant) begin $display("FAIL rot_grant g%0d b%0d got %h want %h", g, b, grantOut, expGrant); mismatched++; end
        compared++;
        if (outValid !== 1'b1) begin $display("FAIL rot_valid g%0d b%0d got %b want 1", g, b, outValid); mismatched++; end
        compared++;
        if (dataOut !== wordOf(int'(expSel))) begin $display("FAIL rot_data g%0d b%0d got %h want %h", g, b, dataOut, wordOf(int'(expSel))); mismatched++; end
        compared++;
        step();
      end
    end
    reqIn = 8'h00;
    step();
  endtask

  task automatic test_backpressure();
    doReset();
    reqIn    = 8'h60;
    outReady = 1'b0;
    step();
    outReady = 1'b1;
    #1;
    if (selectLine !== 3'd5) begin $display("FAIL bp_first_sel got %0d want 5", selectLine); mismatched++; end
    compared++;
    step();
    outReady = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (grantOut !== 8'h20) begin $display("FAIL bp_stall_grant cyc%0d got %h want 20", c, grantOut); mismatched++; end
      compared++;
      if (outValid !== 1'b1) begin $display("FAIL bp_stall_valid cyc%0d got %b want 1", c, outValid); mismatched++; end
      compared++;
      if (dataOut !== wordOf(5)) begin $display("FAIL bp_stall_data cyc%0d got %h want %h", c, dataOut, wordOf(5)); mismatched++; end
      compared++;
      step();
    end
    // One beat was taken before the stall, so exactly three more remain.
    outReady = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (selectLine !== 3'd5) begin $display("FAIL bp_resume_sel cyc%0d got %0d want 5", c, selectLine); mismatched++; end
      compared++;
      step();
    end
    if (selectLine !== 3'd6) begin $display("FAIL bp_rotate_sel got %0d want 6", selectLine); mismatched++; end
    compared++;
    if (grantOut !== 8'h40) begin $display("FAIL bp_rotate_grant got %h want 40", grantOut); mismatched++; end
    compared++;
    reqIn = 8'h00;
    step();
  endtask

  task automatic test_early_drop();
    doReset();
    reqIn    = 8'h20;
    outReady = 1'b1;
    step();
    step();
    outReady = 1'b0;
    reqIn    = 8'h40;
    #1;
    if (outValid !== 1'b0) begin $display("FAIL drop_valid got %b want 0", outValid); mismatched++; end
    compared++;
    if (dataOut !== 8'h00) begin $display("FAIL drop_data got %h want 00", dataOut); mismatched++; end
    compared++;
    if (grantOut !== 8'h20) begin $display("FAIL drop_grant_held got %h want 20", grantOut); mismatched++; end
    compared++;
    step();
    if (selectLine !== 3'd6) begin $display("FAIL drop_next_sel got %0d want 6", selectLine); mismatched++; end
    compared++;
    if (grantOut !== 8'h40) begin $display("FAIL drop_next_grant got %h want 40", grantOut); mismatched++; end
    compared++;
    if (outValid !== 1'b1) begin $display("FAIL drop_next_valid got %b want 1", outValid); mismatched++; end
    compared++;
    if (dataOut !== wordOf(6)) begin $display("FAIL drop_next_data got %h want %h", dataOut, wordOf(6)); mismatched++; end
    compared++;
    reqIn = 8'h00;
    step();
  endtask

  task automatic test_async_reset();
    doReset();
    reqIn    = 8'h05;
    outReady = 1'b1;
    step();
    reqIn = 8'h04;
    step();
    if (selectLine !== 3'd2) begin $display("FAIL areset_pre_sel got %0d want 2", selectLine); mismatched++; end
    compared++;
    step();
    reqIn = 8'h05;
    #2;
    rstN = 1'b0;
    #1;
    if (grantOut !== 8'h00) begin $display("FAIL areset_grant got %h want 00", grantOut); mismatched++; end
    compared++;
    if (outValid !== 1'b0) begin $display("FAIL areset_valid got %b want 0", outValid); mismatched++; end
    compared++;
    if (selectLine !== 3'd0) begin $display("FAIL areset_sel got %0d want 0", selectLine); mismatched++; end
    compared++;
    if (dataOut !== 8'h00) begin $display("FAIL areset_data got %h want 00", dataOut); mismatched++; end
    compared++;
    step();
    rstN = 1'b1;
    step();
    if (selectLine !== 3'd0) begin $display("FAIL areset_first_sel got %0d want 0", selectLine); mismatched++; end
    compared++;
    if (grantOut !== 8'h01) begin $display("FAIL areset_first_grant got %h want 01", grantOut); mismatched++; end
    compared++;
    reqIn = 8'h00;
    step();
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    doReset();
    reqIn    = 8'h02;
    lockIn   = 1'b1;
    outReady = 1'b1;
    step();
    reqIn = 8'h12;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (selectLine !== 3'd1) begin $display("FAIL lock_sel cyc%0d got %0d want 1", c, selectLine); mismatched++; end
      compared++;
      if (outValid !== 1'b1) begin $display("FAIL lock_valid cyc%0d got %b want 1", c, outValid); mismatched++; end
      compared++;
      step();
    end
    lockIn = 1'b0;
    #1;
    if (selectLine !== 3'd1) begin $display("FAIL lock_unlock_sel got %0d want 1", selectLine); mismatched++; end
    compared++;
    step();
    if (selectLine !== 3'd4) begin $display("FAIL lock_release_sel got %0d want 4", selectLine); mismatched++; end
    compared++;
    if (grantOut !== 8'h10) begin $display("FAIL lock_release_grant got %h want 10", grantOut); mismatched++; end
    compared++;
    reqIn = 8'h00;
    step();
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rstN       = 1'b0;
    reqIn      = '0;
    outReady   = 1'b0;
    lockIn     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dataIn[i*DATA_W +: DATA_W] = 8'(8'h11 * i + 8'h0C);
    end
    test_reset();
    test_single_burst();
    test_rotation();
    test_backpressure();
    test_early_drop();
    test_async_reset();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
